// File: rtl/term_matrix_pkg.sv
// term_matrix_pkg: shared mode encoding, sizes and width helpers for the loopback matrix
package term_matrix_pkg;
    typedef enum logic [1:0] {PASS = 2'b00, REG = 2'b01, ZERO = 2'b10, TEST = 2'b11} mode_e;
    localparam int NUM_BUNDLES = 5;
    localparam int CFG_BITS = 2 * NUM_BUNDLES;
    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction
    function automatic bit is_pow2(input int w);
        return (w >= 1) && ((w & (w - 1)) == 0);
    endfunction
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = (a > b) ? a : b;
        m = (c > m) ? c : m;
        return (d > m) ? d : m;
    endfunction
endpackage

// File: rtl/term_loopback_matrix_bundle.sv
// term_bundle: index-reversing fold of one bundle with pass/registered/zero/walking-one modes
module term_bundle
    import term_matrix_pkg::*;
#(
    parameter int W = 4,
    parameter int CW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  mode_e         mode_i,
    input  logic [CW-1:0] cnt_i,
    input  logic [W-1:0]  in_i,
    output logic [W-1:0]  out_o
);
    localparam int LW = cnt_width(W);
    logic [W-1:0] rev, rev_q, pat;
    logic [LW-1:0] pos;
    for (genvar i = 0; i < W; i++) begin : g_rev
        assign rev[i] = in_i[W-1-i];
    end
    // rev_q runs in every mode so a switch to REG never shows a stale value
    always_ff @(posedge clk_i) begin
        if (rst_i) rev_q <= '0;
        else rev_q <= rev;
    end
    assign pos = (W > 1) ? cnt_i[LW-1:0] : '0;
    assign pat = W'(1) << pos;
    always_comb begin
        out_o = (mode_i == PASS) ? rev :
                (mode_i == REG)  ? rev_q :
                (mode_i == ZERO) ? '0 : pat;
    end
endmodule

// File: rtl/term_loopback_matrix.sv
// term_loopback_matrix: north-edge fold-back switch with serially loaded per-bundle modes
module term_loopback_matrix
    import term_matrix_pkg::*;
#(
    parameter int W1 = 4,
    parameter int W2 = 8,
    parameter int W4 = 16,
    parameter int WNN4 = 16
) (
    input  logic            UserCLK,
    input  logic            Reset,
    input  logic            ConfigIn,
    input  logic            ConfigEn,
    input  logic            ConfigLatch,
    output logic            ConfigOut,
    input  logic            TestRun,
    input  logic [W1-1:0]   N1END,
    output logic [W1-1:0]   S1BEG,
    input  logic [W2-1:0]   N2MID,
    output logic [W2-1:0]   S2BEG,
    input  logic [W2-1:0]   N2END,
    output logic [W2-1:0]   S2BEGb,
    input  logic [W4-1:0]   N4END,
    output logic [W4-1:0]   S4BEG,
    input  logic [WNN4-1:0] NN4END,
    output logic [WNN4-1:0] SS4BEG
);
    localparam int CW = cnt_width(max4(W1, W2, W4, WNN4));
    if (!is_pow2(W1) || !is_pow2(W2) || !is_pow2(W4) || !is_pow2(WNN4)) begin : g_bad_width
        $error("term_loopback_matrix: every bundle width must be a power of 2");
    end
    logic [CFG_BITS-1:0] shadow_q, shadow_d, active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // latch reads the pre-shift shadow when shift and latch coincide
    always_comb begin
        shadow_d = ConfigEn ? {shadow_q[CFG_BITS-2:0], ConfigIn} : shadow_q;
        active_d = ConfigLatch ? shadow_q : active_q;
        cnt_d = TestRun ? cnt_q + CW'(1) : cnt_q;
    end
    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            shadow_q <= '0;
            active_q <= '0;
            cnt_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q <= cnt_d;
        end
    end
    assign ConfigOut = shadow_q[CFG_BITS-1];
    term_bundle #(.W(W1), .CW(CW)) u_b0 (
        .clk_i(UserCLK), .rst_i(Reset), .mode_i(mode_e'(active_q[1:0])),
        .cnt_i(cnt_q), .in_i(N1END), .out_o(S1BEG)
    );
    term_bundle #(.W(W2), .CW(CW)) u_b1 (
        .clk_i(UserCLK), .rst_i(Reset), .mode_i(mode_e'(active_q[3:2])),
        .cnt_i(cnt_q), .in_i(N2MID), .out_o(S2BEG)
    );
    term_bundle #(.W(W2), .CW(CW)) u_b2 (
        .clk_i(UserCLK), .rst_i(Reset), .mode_i(mode_e'(active_q[5:4])),
        .cnt_i(cnt_q), .in_i(N2END), .out_o(S2BEGb)
    );
    term_bundle #(.W(W4), .CW(CW)) u_b3 (
        .clk_i(UserCLK), .rst_i(Reset), .mode_i(mode_e'(active_q[7:6])),
        .cnt_i(cnt_q), .in_i(N4END), .out_o(S4BEG)
    );
    term_bundle #(.W(WNN4), .CW(CW)) u_b4 (
        .clk_i(UserCLK), .rst_i(Reset), .mode_i(mode_e'(active_q[9:8])),
        .cnt_i(cnt_q), .in_i(NN4END), .out_o(SS4BEG)
    );
endmodule

// File: tb/tb_term_loopback_matrix.sv
// tb_term_loopback_matrix: directed scenarios plus random traffic checked against a behavioural model
module tb_term_loopback_matrix;
    logic UserCLK = 0, Reset, ConfigIn, ConfigEn, ConfigLatch, ConfigOut, TestRun;
    logic [3:0] N1END, S1BEG;
    logic [7:0] N2MID, S2BEG, N2END, S2BEGb;
    logic [15:0] N4END, S4BEG, NN4END, SS4BEG;
    int n_chk = 0, n_pass = 0;
    logic [9:0] m_shadow, m_active;
    int m_cnt;
    logic [31:0] d[5], p[5];
    int wid[5] = '{4, 8, 8, 16, 16};

    term_loopback_matrix dut (
        .UserCLK(UserCLK), .Reset(Reset), .ConfigIn(ConfigIn), .ConfigEn(ConfigEn),
        .ConfigLatch(ConfigLatch), .ConfigOut(ConfigOut), .TestRun(TestRun),
        .N1END(N1END), .S1BEG(S1BEG), .N2MID(N2MID), .S2BEG(S2BEG),
        .N2END(N2END), .S2BEGb(S2BEGb), .N4END(N4END), .S4BEG(S4BEG),
        .NN4END(NN4END), .SS4BEG(SS4BEG)
    );

    always #5 UserCLK = ~UserCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] reverse(input logic [31:0] x, input int w);
        logic [31:0] r = 0;
        for (int i = 0; i < w; i++) if (x[i]) r |= 32'(1) << (w - 1 - i);
        return r;
    endfunction

    // expected output of bundle k from the documented mode rules
    function automatic logic [31:0] expect_out(input int k);
        int mode = int'((m_active >> (2 * k)) & 10'h3);
        int w = wid[k];
        if (mode == 0) return reverse(d[k], w);
        if (mode == 1) return reverse(p[k], w);
        if (mode == 2) return 0;
        return 32'(1) << (m_cnt % w);
    endfunction

    task automatic model_reset();
        m_shadow = 0; m_active = 0; m_cnt = 0;
        for (int k = 0; k < 5; k++) p[k] = 0;
    endtask

    task automatic cyc(input logic rst, input logic en, input logic ci, input logic lat, input logic tr);
        Reset = rst; ConfigEn = en; ConfigIn = ci; ConfigLatch = lat; TestRun = tr;
        N1END = d[0][3:0]; N2MID = d[1][7:0]; N2END = d[2][7:0];
        N4END = d[3][15:0]; NN4END = d[4][15:0];
        #2;
        check("S1BEG", 32'(S1BEG), expect_out(0));
        check("S2BEG", 32'(S2BEG), expect_out(1));
        check("S2BEGb", 32'(S2BEGb), expect_out(2));
        check("S4BEG", 32'(S4BEG), expect_out(3));
        check("SS4BEG", 32'(SS4BEG), expect_out(4));
        check("ConfigOut", 32'(ConfigOut), 32'(m_shadow[9]));
        @(posedge UserCLK);
        if (rst) model_reset();
        else begin
            if (lat) m_active = m_shadow;
            if (en) m_shadow = {m_shadow[8:0], ci};
            if (tr) m_cnt = (m_cnt + 1) % 16;
            for (int k = 0; k < 5; k++) p[k] = d[k];
        end
        #1;
    endtask

    task automatic randomize_data();
        for (int k = 0; k < 5; k++) d[k] = $urandom & ((32'(1) << wid[k]) - 1);
    endtask

    task automatic load(input logic [9:0] v);
        logic [9:0] b = v;
        for (int i = 9; i >= 0; i--) begin
            randomize_data();
            cyc(0, 1, b[i], 0, 0);
        end
        randomize_data();
        cyc(0, 0, 0, 1, 0);
    endtask

    initial begin
        logic [9:0] v155 = 10'h155;
        Reset = 1; ConfigEn = 0; ConfigIn = 0; ConfigLatch = 0; TestRun = 0;
        for (int k = 0; k < 5; k++) d[k] = 0;
        N1END = 0; N2MID = 0; N2END = 0; N4END = 0; NN4END = 0;
        repeat (2) @(posedge UserCLK);
        #1;
        model_reset();
        randomize_data();
        d[3] = 32'h0001; d[0] = 32'h3;
        cyc(0, 0, 0, 0, 0);
        check("reset_s4_fold", 32'(S4BEG), 32'h8000);
        check("reset_s1_fold", 32'(S1BEG), 32'hC);

        load(10'b00_00_00_00_01);
        randomize_data(); d[0] = 32'h1;
        cyc(0, 0, 0, 0, 0);
        randomize_data(); d[0] = 32'h0;
        cyc(0, 0, 0, 0, 0);
        check("reg_latency", 32'(S1BEG), 32'h0);
        randomize_data(); d[0] = 32'h5;
        Reset = 0; N1END = 4'h5;
        #2;
        check("reg_prev_zero_in", 32'(S1BEG), 32'h0);

        load(10'b00_11_00_00_11);
        for (int i = 0; i < 20; i++) begin
            randomize_data();
            cyc(0, 0, 0, 0, 1);
        end

        load(10'h2AA);
        d[0] = 32'hF; d[1] = 32'hFF; d[2] = 32'hFF; d[3] = 32'hFFFF; d[4] = 32'hFFFF;
        cyc(0, 0, 0, 0, 0);
        check("zero_s4", 32'(S4BEG), 32'h0);
        cyc(1, 0, 0, 0, 0);
        d[3] = 32'h0003;
        cyc(0, 0, 0, 0, 0);
        check("post_reset_pass", 32'(S4BEG), 32'hC000);

        for (int i = 9; i >= 0; i--) begin
            randomize_data();
            cyc(0, 1, v155[i], 0, 0);
        end
        randomize_data();
        cyc(0, 1, 1, 1, 0);
        check("dual_active", 32'(dut.active_q), 32'h155);
        check("dual_shadow", 32'(dut.shadow_q), 32'h2AB);

        load(10'h0);
        for (int i = 0; i < 5; i++) begin
            randomize_data();
            cyc(0, 1, 1, 0, 0);
        end
        randomize_data();
        cyc(1, 1, 1, 1, 0);
        check("abort_shadow", 32'(dut.shadow_q), 32'h0);
        check("abort_active", 32'(dut.active_q), 32'h0);
        load(10'h1E4);
        check("reload_active", 32'(dut.active_q), 32'h1E4);

        for (int i = 0; i < 400; i++) begin
            randomize_data();
            cyc($urandom_range(0, 49) == 0, 1'($urandom), 1'($urandom),
                $urandom_range(0, 7) == 0, 1'($urandom));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
